// File: rtl/gauss_pkg.sv
// Shared definitions for the Gaussian stream sequencer.
// Holds the FSM state encoding, the default frame geometry and filter
// latency, and a constant clog2 helper used to size the counters.
package gauss_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_PAD    = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int DEF_IMG_W = 400;
    localparam int DEF_IMG_H = 300;
    localparam int DEF_PAD   = 3;
    localparam int DEF_PRIME = 806;

    // Ceiling log2; callers pass (max_value + 1) so every width is >= 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gauss_mod_counter.sv
// Modulo counter used for the input and output column positions.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en         advance by one (wraps from MODULUS-1 to 0)
//   clr        return to 0; wins over en
//   count      current value, 0..MODULUS-1
//   wrap       high while count sits at its terminal value MODULUS-1
module gauss_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    assign wrap = (count == LAST);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/gauss_stream_sequencer.sv
// Sequences one frame through the Gaussian line-buffer filter.
// Pops pixels from the upstream FIFO, appends PAD zero slots after every
// row, then flushes zeros until every real pixel has left the filter.
// Downstream writes start once the filter is primed (PRIME slots) and skip
// pad positions. Every slot stalls while the downstream FIFO is full.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a frame (honoured only in IDLE)
//   in_valid/in_data    upstream FIFO not-empty flag and head pixel
//   in_rd_en            upstream pop
//   g_din/g_clk_en      filter input and slot advance
//   g_dout              filter output
//   out_full            downstream FIFO full
//   out_wr_en/out_data  downstream push and data (= g_dout)
//   busy                high outside IDLE
//   done                one-cycle end-of-frame pulse
module gauss_stream_sequencer
    import gauss_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int PAD    = DEF_PAD,
    parameter int PRIME  = DEF_PRIME
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_rd_en,
    output logic [DATA_W-1:0] g_din,
    output logic              g_clk_en,
    input  logic [DATA_W-1:0] g_dout,
    input  logic              out_full,
    output logic              out_wr_en,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int SPAN    = IMG_W + PAD;
    localparam int TOTAL   = IMG_W * IMG_H;
    localparam int COL_W   = clog2(SPAN + 1);
    localparam int PRIME_W = clog2(PRIME + 1);
    localparam int CNT_W   = clog2(TOTAL + 1);
    localparam int ROW_W   = clog2(IMG_H + 1);

    localparam logic [COL_W-1:0]   LAST_PIX  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]   ROW_PIXS  = COL_W'(IMG_W);
    localparam logic [PRIME_W-1:0] PRIME_C   = PRIME_W'(PRIME);
    localparam logic [CNT_W-1:0]   TOTAL_C   = CNT_W'(TOTAL);
    localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(IMG_H - 1);

    state_t             state, state_nxt;
    logic               slot;
    logic               clr;
    logic [COL_W-1:0]   in_col, out_col;
    logic               row_end;
    logic               out_wrap_unused;
    logic [PRIME_W-1:0] prime_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [ROW_W-1:0]   in_row;
    logic               prime_full;
    logic               last_row;
    logic               frame_written;

    assign prime_full    = (prime_cnt == PRIME_C);
    assign last_row      = (in_row == LAST_ROW);
    assign frame_written = (out_cnt == TOTAL_C);

    assign g_clk_en  = slot;
    assign out_data  = g_dout;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    // Pad columns of the output stream and anything past the frame's last
    // pixel are consumed by the filter but never pushed downstream.
    assign out_wr_en = slot && prime_full && (out_col < ROW_PIXS) && !frame_written;

    gauss_mod_counter #(.WIDTH(COL_W), .MODULUS(SPAN)) u_in_col (
        .clk   (clk),
        .rst   (rst),
        .en    (slot),
        .clr   (clr),
        .count (in_col),
        .wrap  (row_end)
    );

    gauss_mod_counter #(.WIDTH(COL_W), .MODULUS(SPAN)) u_out_col (
        .clk   (clk),
        .rst   (rst),
        .en    (slot && prime_full),
        .clr   (clr),
        .count (out_col),
        .wrap  (out_wrap_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            prime_cnt <= '0;
            out_cnt   <= '0;
            in_row    <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                prime_cnt <= '0;
                out_cnt   <= '0;
                in_row    <= '0;
            end else begin
                if (slot && !prime_full) prime_cnt <= prime_cnt + PRIME_W'(1);
                if (out_wr_en)           out_cnt   <= out_cnt + CNT_W'(1);
                if (state == S_PAD && slot && row_end && !last_row)
                    in_row <= in_row + ROW_W'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        slot      = 1'b0;
        clr       = 1'b0;
        in_rd_en  = 1'b0;
        g_din     = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_STREAM;
                    clr       = 1'b1;
                end
            end
            S_STREAM: begin
                if (in_valid && !out_full) begin
                    slot     = 1'b1;
                    in_rd_en = 1'b1;
                    g_din    = in_data;
                    if (in_col == LAST_PIX) state_nxt = S_PAD;
                end
            end
            S_PAD: begin
                if (!out_full) begin
                    slot = 1'b1;
                    if (row_end) state_nxt = last_row ? S_FLUSH : S_STREAM;
                end
            end
            S_FLUSH: begin
                // Once the last pixel has been written the filter needs no
                // further drain slots.
                if (frame_written)  state_nxt = S_DONE;
                else if (!out_full) slot      = 1'b1;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gauss_stream_sequencer.sv
// Directed bench for gauss_stream_sequencer at IMG_W=8, IMG_H=4, PAD=2,
// PRIME=22. The filter is modelled as a pure PRIME-slot delay line, so the
// downstream writes must reproduce the input ramp 1..32 in order.
module tb_gauss_stream_sequencer;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int PAD    = 2;
    localparam int PRIME  = 22;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int BUDGET = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_rd_en;
    logic [DATA_W-1:0] g_din;
    logic              g_clk_en;
    logic [DATA_W-1:0] g_dout;
    logic              out_full;
    logic              out_wr_en;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] hist [PRIME];
    assign g_dout = hist[PRIME-1];

    int n_checks = 0;
    int n_errors = 0;

    // Per-frame observations
    int cyc, slots, pops, writes, zero_slots, dones, done_cyc;
    int first_pop_slot, first_wr_slot;
    int stall_viol, rd_viol, wr_viol, pad_data_viol;
    int cap [NPIX];

    always #5 clk = ~clk;

    gauss_stream_sequencer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PAD    (PAD),
        .PRIME  (PRIME)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_rd_en  (in_rd_en),
        .g_din     (g_din),
        .g_clk_en  (g_clk_en),
        .g_dout    (g_dout),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one frame. bubbles: in_valid toggles every cycle (low in the first
    // STREAM cycle). stalls: out_full for 5 cycles once 10, 25 and 40 slots
    // have passed. rst_slot >= 0 aborts the frame after that many slots.
    // start_again re-pulses start mid-frame and during the DONE cycle.
    task automatic run_frame(input string name, input bit bubbles, input bit stalls,
                             input int rst_slot, input bit start_again,
                             input int exp_done_cyc);
        int  stall_at [3];
        int  stall_idx, stall_left, bad;
        bit  finished, aborted, popped;
        stall_at = '{10, 25, 40};
        stall_idx = 0; stall_left = 0;
        cyc = 0; slots = 0; pops = 0; writes = 0; zero_slots = 0; dones = 0;
        done_cyc = -1; first_pop_slot = -1; first_wr_slot = -1;
        stall_viol = 0; rd_viol = 0; wr_viol = 0; pad_data_viol = 0;
        finished = 1'b0; aborted = 1'b0;
        for (int i = 0; i < PRIME; i++) hist[i] = '0;
        for (int i = 0; i < NPIX; i++) cap[i] = -1;

        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; out_full = 1'b0; in_data = 8'd1;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            popped = 1'b0;
            if (rst) begin
                aborted  = 1'b1;
                finished = 1'b1;
            end
            if (g_clk_en && out_full) stall_viol++;
            if (in_rd_en && (!g_clk_en || !in_valid)) rd_viol++;
            if (out_wr_en && !g_clk_en) wr_viol++;
            if (g_clk_en) begin
                if (in_rd_en) begin
                    pops++;
                    popped = 1'b1;
                    if (first_pop_slot < 0) first_pop_slot = slots;
                end else begin
                    zero_slots++;
                    if (g_din != '0) pad_data_viol++;
                end
                if (out_wr_en) begin
                    if (writes < NPIX) cap[writes] = int'(out_data);
                    if (first_wr_slot < 0) first_wr_slot = slots;
                    writes++;
                end
                for (int i = PRIME - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = g_din;
                slots++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                finished = 1'b1;
            end
            if (cyc >= BUDGET && !finished) begin
                check({name, "_timeout"}, cyc, exp_done_cyc);
                finished = 1'b1;
            end

            @(posedge clk); #1;
            if (popped) in_data = in_data + 8'd1;
            start    = start_again && (cyc == 9 || cyc == 62);
            in_valid = bubbles ? !in_valid : 1'b1;
            if (stalls && stall_left == 0 && stall_idx < 3 && slots >= stall_at[stall_idx]) begin
                stall_left = 5;
                stall_idx++;
            end
            out_full = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            rst = (rst_slot >= 0 && slots == rst_slot && !aborted && !rst);
        end

        @(negedge clk);
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_done_after"}, int'(done), 0);
        check({name, "_stall_viol"}, stall_viol, 0);
        check({name, "_rd_viol"}, rd_viol, 0);
        check({name, "_wr_viol"}, wr_viol, 0);
        if (aborted) begin
            check({name, "_slot_after_rst"}, int'(g_clk_en), 0);
            check({name, "_done_count"}, dones, 0);
            check({name, "_writes"}, writes, 0);
        end else begin
            check({name, "_pops"}, pops, NPIX);
            check({name, "_writes"}, writes, NPIX);
            check({name, "_slots"}, slots, 60);
            check({name, "_zero_slots"}, zero_slots, 28);
            check({name, "_pad_data"}, pad_data_viol, 0);
            check({name, "_first_pop"}, first_pop_slot, 0);
            check({name, "_latency"}, first_wr_slot - first_pop_slot, PRIME);
            check({name, "_done_count"}, dones, 1);
            check({name, "_done_cyc"}, done_cyc, exp_done_cyc);
            bad = 0;
            for (int i = 0; i < NPIX; i++) if (cap[i] != i + 1) bad++;
            check({name, "_data"}, bad, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = '0; out_full = 1'b0;
        for (int i = 0; i < PRIME; i++) hist[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_en", int'(in_rd_en), 0);
        check("reset_clk_en", int'(g_clk_en), 0);
        check("reset_wr_en", int'(out_wr_en), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_slot", int'(g_clk_en), 0);

        run_frame("nominal",   1'b0, 1'b0, -1, 1'b0, 63);
        run_frame("bubbles",   1'b1, 1'b0, -1, 1'b0, 95);
        run_frame("backpress", 1'b0, 1'b1, -1, 1'b0, 78);
        run_frame("midreset",  1'b0, 1'b0, 15, 1'b0, 0);
        run_frame("rerun",     1'b0, 1'b0, -1, 1'b0, 63);
        run_frame("start_busy", 1'b0, 1'b0, -1, 1'b1, 63);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
